nec_ir_rx: RTL and testbench
============================

// Module: nec_ir_rx
// PURPOSE
//  Parametrised NEC infrared frame decoder for HS0038B-style receivers.
//  Captures the full 32-bit frame, checks the inverse bytes, and flags repeat codes.
//  Tracks a held key with a timeout and reports error causes.
//  Sits between the board IR pin and display/LED logic (seg_led, led_ctrl).
//  Its data/repeat outputs replace the earlier fixed-clock 8-bit decoder.
// PARAMETERS
//  CLK_FREQ     50_000_000  sys_clk frequency in Hz; sets a 10 us tick prescaler (CLK_FREQ/100_000)
//  ADDR_CHECK   0           1: require addr[15:8] == ~addr[7:0] (classic NEC); 0: 16-bit extended address
//  HOLD_TMO_MS  120         key_held drops if no repeat code arrives within this many ms
// PORTS
//  sys_clk     in   1   system clock
//  sys_rst_n   in   1   asynchronous active-low reset
//  remote_in   in   1   raw IR receiver output; idle high, burst = low
//  frame_valid out  1   1-cycle pulse: new valid frame on addr/cmd
//  repeat_en   out  1   1-cycle pulse: valid repeat code while key_held
//  key_held    out  1   level; high from frame_valid until hold timeout
//  addr        out  16  last valid address, LSB-first order {byte1,byte0}
//  cmd         out  8   last valid command byte
//  err_pulse   out  1   1-cycle pulse on any aborted/invalid frame
//  err_code    out  2   0 timing, 1 cmd check, 2 addr check, 3 timeout; held until next error
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; tick counter and width counter cleared.
//  - remote_in passes a 2-FF synchroniser, then edge detect. All timing is in 10 us ticks.
//    The width counter saturates at 1400 ticks (14 ms).
//  - FSM states: IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, STOP.
//    IDLE -> LEAD_LO on falling edge.
//    LEAD_LO on rise: 800..1000 ticks -> LEAD_HI, else timing error.
//    LEAD_HI on fall: 400..500 -> BIT_LO (bit index 0); 200..250 -> STOP (repeat path); else error.
//    BIT_LO on rise: 40..70 -> BIT_HI, else error.
//    BIT_HI on fall: 40..70 shifts in 0; 140..190 shifts in 1; else error.
//    After bit 31 -> STOP, otherwise -> BIT_LO.
//    STOP on rise: 40..70 finishes the frame or repeat, else error; return to IDLE.
//  - Any state other than IDLE with the counter reaching 1400 -> err_code 3, IDLE.
//  - Bits are shifted LSB-first into a 32-bit register: [7:0] addr, [15:8] addr_n/addr_hi, [23:16] cmd, [31:24] cmd_n.
//  - Frame completion, checked in order: cmd_n == ~cmd, else code 1.
//    Then, if ADDR_CHECK=1, addr_hi == ~addr_lo, else code 2.
//    On pass, addr/cmd update and frame_valid pulses.
//    Latency: 1 cycle after the synchronised STOP rising edge.
//  - Repeat completion: repeat_en pulses only if key_held=1; otherwise silently ignored, no error.
//    A valid repeat reloads the hold timer.
//  - key_held: set with frame_valid; the hold timer reloads to HOLD_TMO_MS*100 ticks.
//    Cleared when the timer expires. A new frame while held re-pulses frame_valid and reloads the timer.
//  - Errors: err_pulse plus err_code update; addr/cmd keep old values.
//    key_held is unaffected, except that an error does not reload the timer.
//  - A falling edge seen while not expected (glitch < 40 ticks) is treated as a timing error.
//  - Async reset mid-frame discards partial data; the next frame decodes normally.
// STRUCTURE
//  - Shared package nec_ir_pkg: state enum encoding (localparams) and tick window constants
//    (LEAD_LO_MIN/MAX, LEAD_HI_DATA/RPT bounds, BIT_MIN/MAX, ONE_MIN/MAX, TMO_TICKS).
//  - One sub-module, ir_tick_gen: CLK_FREQ-parametrised 10 us strobe.
//  - Top contains the synchroniser, the FSM/shift register and the hold timer.
// TESTING
//  1. Frame addr=0x00, cmd=0x45 (bytes 00 FF 45 BA), CLK_FREQ=50 MHz
//     -> frame_valid once, addr=0xFF00, cmd=0x45, key_held=1.
//  2. Same frame, then repeats every 108 ms x3
//     -> 3 repeat_en pulses, key_held stays 1; it falls ~120 ms after the last repeat.
//  3. Repeat code with no prior frame -> no repeat_en, no err_pulse, key_held=0.
//  4. Frame with cmd_n corrupted to 0xBB -> err_pulse, err_code=1, addr/cmd unchanged, no frame_valid.
//  5. ADDR_CHECK=1 with addr bytes 0x12 0x34 -> err_code=2; ADDR_CHECK=0 -> addr=0x3412 valid.
//  6. Line held low 15 ms mid-frame -> err_code=3, FSM returns to IDLE, next good frame decodes.
//     Also: reset asserted at bit 16 -> all outputs 0, next frame decodes.

Source files
------------

// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC IR receiver: FSM state encoding, error codes
// and the pulse-width windows, all expressed in 10 us ticks.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEAD_LO = 3'd1,
    ST_LEAD_HI = 3'd2,
    ST_BIT_LO  = 3'd3,
    ST_BIT_HI  = 3'd4,
    ST_STOP    = 3'd5
  } nec_state_t;

  localparam int TICK_HZ = 100_000;
  localparam int WCNT_W  = 11;

  localparam int LEAD_LO_MIN      = 800;
  localparam int LEAD_LO_MAX      = 1000;
  localparam int LEAD_HI_DATA_MIN = 400;
  localparam int LEAD_HI_DATA_MAX = 500;
  localparam int LEAD_HI_RPT_MIN  = 200;
  localparam int LEAD_HI_RPT_MAX  = 250;
  localparam int BIT_MIN          = 40;
  localparam int BIT_MAX          = 70;
  localparam int ONE_MIN          = 140;
  localparam int ONE_MAX          = 190;

  // Width counter saturation point; reaching it in any active state aborts the frame.
  localparam logic [WCNT_W-1:0] TMO_TICKS = 11'd1400;

  localparam logic [1:0] ERR_TIMING = 2'd0;
  localparam logic [1:0] ERR_CMD    = 2'd1;
  localparam logic [1:0] ERR_ADDR   = 2'd2;
  localparam logic [1:0] ERR_TMO    = 2'd3;

  function automatic logic in_win(input logic [WCNT_W-1:0] width, input int lo, input int hi);
    return (int'(width) >= lo) && (int'(width) <= hi);
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// 10 us strobe derived from the system clock; a divide ratio of 1 yields a
// strobe on every cycle.
module ir_tick_gen
  import nec_ir_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam int DIV = (CLK_FREQ / TICK_HZ < 1) ? 1 : CLK_FREQ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == CW'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/nec_ir_rx.sv
// NEC IR frame decoder: synchroniser, pulse-width FSM with 32-bit shift
// register, inverse-byte checks and a key-hold timer refreshed by repeat codes.
module nec_ir_rx
  import nec_ir_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int ADDR_CHECK  = 0,
  parameter int HOLD_TMO_MS = 120
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        remote_in,
  output logic        frame_valid,
  output logic        repeat_en,
  output logic        key_held,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        err_pulse,
  output logic [1:0]  err_code
);

  localparam int HOLD_TICKS = HOLD_TMO_MS * 100;
  localparam int HW         = $clog2(HOLD_TICKS + 1);

  logic              tick;
  logic [2:0]        sync_reg;
  logic              rise;
  logic              fall;
  logic [WCNT_W-1:0] wcnt;
  nec_state_t        state;
  logic [4:0]        bit_idx;
  logic [31:0]       shreg;
  logic              rpt_flag;
  logic [HW-1:0]     hold_cnt;
  logic              bad_edge;
  logic              timeout;
  logic              stop_ok;
  logic              cmd_ok;
  logic              addr_ok;
  logic              frame_done;
  logic              rpt_ok;

  ir_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (tick)
  );

  // Synchroniser resets to the idle-high level so reset release never looks like a burst.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], remote_in};
    end
  end

  assign rise = sync_reg[1] & ~sync_reg[2];
  assign fall = ~sync_reg[1] & sync_reg[2];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wcnt <= '0;
    end else if (rise || fall) begin
      wcnt <= '0;
    end else if (tick && (wcnt != TMO_TICKS)) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // An edge is bad when it has the wrong polarity for the state or misses every window.
  always_comb begin
    bad_edge = 1'b0;
    case (state)
      ST_LEAD_LO: bad_edge = fall || (rise && !in_win(wcnt, LEAD_LO_MIN, LEAD_LO_MAX));
      ST_LEAD_HI: bad_edge = rise || (fall && !in_win(wcnt, LEAD_HI_DATA_MIN, LEAD_HI_DATA_MAX)
                                           && !in_win(wcnt, LEAD_HI_RPT_MIN, LEAD_HI_RPT_MAX));
      ST_BIT_LO:  bad_edge = fall || (rise && !in_win(wcnt, BIT_MIN, BIT_MAX));
      ST_BIT_HI:  bad_edge = rise || (fall && !in_win(wcnt, BIT_MIN, BIT_MAX)
                                           && !in_win(wcnt, ONE_MIN, ONE_MAX));
      ST_STOP:    bad_edge = fall || (rise && !in_win(wcnt, BIT_MIN, BIT_MAX));
      default:    bad_edge = 1'b0;
    endcase
  end

  assign timeout    = (state != ST_IDLE) && (wcnt == TMO_TICKS);
  assign stop_ok    = (state == ST_STOP) && rise && in_win(wcnt, BIT_MIN, BIT_MAX);
  assign cmd_ok     = (shreg[31:24] == ~shreg[23:16]);
  assign addr_ok    = (ADDR_CHECK == 0) || (shreg[15:8] == ~shreg[7:0]);
  assign frame_done = stop_ok && !rpt_flag && cmd_ok && addr_ok;
  assign rpt_ok     = stop_ok && rpt_flag && key_held;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      bit_idx     <= '0;
      shreg       <= '0;
      rpt_flag    <= 1'b0;
      frame_valid <= 1'b0;
      repeat_en   <= 1'b0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_TIMING;
      addr        <= '0;
      cmd         <= '0;
    end else begin
      frame_valid <= frame_done;
      repeat_en   <= rpt_ok;
      err_pulse   <= 1'b0;
      if (timeout) begin
        err_pulse <= 1'b1;
        err_code  <= ERR_TMO;
        state     <= ST_IDLE;
      end else if (bad_edge) begin
        err_pulse <= 1'b1;
        err_code  <= ERR_TIMING;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (fall) begin
              state    <= ST_LEAD_LO;
              bit_idx  <= '0;
              rpt_flag <= 1'b0;
            end
          end
          ST_LEAD_LO: begin
            if (rise) state <= ST_LEAD_HI;
          end
          ST_LEAD_HI: begin
            if (fall) begin
              if (in_win(wcnt, LEAD_HI_DATA_MIN, LEAD_HI_DATA_MAX)) begin
                state    <= ST_BIT_LO;
                bit_idx  <= '0;
                rpt_flag <= 1'b0;
              end else begin
                state    <= ST_STOP;
                rpt_flag <= 1'b1;
              end
            end
          end
          ST_BIT_LO: begin
            if (rise) state <= ST_BIT_HI;
          end
          ST_BIT_HI: begin
            if (fall) begin
              // LSB-first: the first bit received ends up in shreg[0].
              shreg   <= {in_win(wcnt, ONE_MIN, ONE_MAX), shreg[31:1]};
              bit_idx <= bit_idx + 1'b1;
              state   <= (bit_idx == 5'd31) ? ST_STOP : ST_BIT_LO;
            end
          end
          ST_STOP: begin
            if (rise) begin
              state <= ST_IDLE;
              if (frame_done) begin
                addr <= shreg[15:0];
                cmd  <= shreg[23:16];
              end else if (!rpt_flag) begin
                err_pulse <= 1'b1;
                err_code  <= cmd_ok ? ERR_ADDR : ERR_CMD;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Hold timer: any accepted frame or repeat reloads it; errors leave it running.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_held <= 1'b0;
      hold_cnt <= '0;
    end else if (frame_done || rpt_ok) begin
      key_held <= 1'b1;
      hold_cnt <= HW'(HOLD_TICKS);
    end else if (key_held && tick) begin
      if (hold_cnt <= HW'(1)) begin
        key_held <= 1'b0;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_rx.sv
// Drives NEC waveforms into two decoders (extended and classic address) and
// compares pulses and outputs against table constants and a frame-rule model.
module tb_nec_ir_rx;

  localparam int CLK_FREQ   = 100_000;
  localparam int HOLD_MS    = 20;
  localparam int HOLD_TICKS = HOLD_MS * 100;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic remote_in = 1'b1;

  logic        fv[2];
  logic        rp[2];
  logic        kh[2];
  logic        ep[2];
  logic [15:0] ad[2];
  logic [7:0]  cm[2];
  logic [1:0]  ec[2];

  nec_ir_rx #(.CLK_FREQ(CLK_FREQ), .ADDR_CHECK(0), .HOLD_TMO_MS(HOLD_MS)) dut_ext (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .remote_in(remote_in),
    .frame_valid(fv[0]), .repeat_en(rp[0]), .key_held(kh[0]),
    .addr(ad[0]), .cmd(cm[0]), .err_pulse(ep[0]), .err_code(ec[0])
  );

  nec_ir_rx #(.CLK_FREQ(CLK_FREQ), .ADDR_CHECK(1), .HOLD_TMO_MS(HOLD_MS)) dut_cls (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .remote_in(remote_in),
    .frame_valid(fv[1]), .repeat_en(rp[1]), .key_held(kh[1]),
    .addr(ad[1]), .cmd(cm[1]), .err_pulse(ep[1]), .err_code(ec[1])
  );

  always #5 sys_clk = ~sys_clk;

  int     fv_cnt[2] = '{0, 0};
  int     rp_cnt[2] = '{0, 0};
  int     ep_cnt[2] = '{0, 0};
  longint cyc = 0;

  always @(negedge sys_clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (sys_rst_n) begin
        if (fv[d]) fv_cnt[d]++;
        if (rp[d]) rp_cnt[d]++;
        if (ep[d]) ep_cnt[d]++;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  int s_fv[2];
  int s_rp[2];
  int s_ep[2];

  logic [15:0] m_addr[2];
  logic [7:0]  m_cmd[2];
  logic [1:0]  m_ec[2];
  bit          m_has[2];
  longint      m_t[2];

  typedef struct {
    logic [31:0] data;   // byte0 in [7:0], sent first
    logic [1:0]  ok;     // per dut: frame accepted
    logic [3:0]  ec;     // per dut err_code afterwards
    logic [31:0] addr;   // per dut addr afterwards
    logic [15:0] cmd;    // per dut cmd afterwards
    logic [1:0]  held;   // per dut key_held afterwards
  } vec_t;

  vec_t tbl[3];

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    remote_in = lvl;
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic send_lead(input bit rpt);
    drive(1'b0, rnd(805, 995));
    if (rpt) drive(1'b1, rnd(205, 245));
    else drive(1'b1, rnd(405, 495));
  endtask

  task automatic send_bits(input logic [31:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drive(1'b0, rnd(43, 67));
      drive(1'b1, data[i] ? rnd(143, 187) : rnd(43, 67));
    end
  endtask

  task automatic send_frame(input logic [31:0] data, output longint t_stop);
    send_lead(1'b0);
    send_bits(data, 32);
    drive(1'b0, rnd(43, 67));
    t_stop = cyc;
    drive(1'b1, 25);
  endtask

  task automatic send_repeat(output longint t_stop);
    send_lead(1'b1);
    drive(1'b0, rnd(43, 67));
    t_stop = cyc;
    drive(1'b1, 25);
  endtask

  function automatic bit held_at(input int d, input longint t);
    return m_has[d] && ((t - m_t[d]) < HOLD_TICKS);
  endfunction

  // Frame rule: -1 accepted, otherwise the error code a decoder must report.
  function automatic int frame_verdict(input logic [31:0] data, input bit classic);
    logic [7:0] b[4];
    for (int k = 0; k < 4; k++) b[k] = data[8*k +: 8];
    if ((b[2] ^ b[3]) != 8'hFF) return 1;
    if (classic && ((b[0] ^ b[1]) != 8'hFF)) return 2;
    return -1;
  endfunction

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      s_fv[d] = fv_cnt[d];
      s_rp[d] = rp_cnt[d];
      s_ep[d] = ep_cnt[d];
    end
  endtask

  task automatic check_pulses(input string name, input int d, input int e_fv, input int e_rp, input int e_ep);
    check({name, ".frame_valid"}, d, 32'(fv_cnt[d] - s_fv[d]), 32'(e_fv));
    check({name, ".repeat_en"},   d, 32'(rp_cnt[d] - s_rp[d]), 32'(e_rp));
    check({name, ".err_pulse"},   d, 32'(ep_cnt[d] - s_ep[d]), 32'(e_ep));
  endtask

  task automatic check_model(input string name, input int d);
    longint dt;
    check({name, ".addr"},     d, 32'(ad[d]), 32'(m_addr[d]));
    check({name, ".cmd"},      d, 32'(cm[d]), 32'(m_cmd[d]));
    check({name, ".err_code"}, d, 32'(ec[d]), 32'(m_ec[d]));
    dt = cyc - m_t[d];
    if (!m_has[d] || dt > HOLD_TICKS + 30) check({name, ".key_held"}, d, 32'(kh[d]), 32'd0);
    else if (dt < HOLD_TICKS - 30)          check({name, ".key_held"}, d, 32'(kh[d]), 32'd1);
  endtask

  task automatic report(input string name);
    $display("txn %-12s | ext: fv=%0d rp=%0d ep=%0d addr=%h cmd=%h ec=%0d held=%0b | cls: fv=%0d rp=%0d ep=%0d addr=%h cmd=%h ec=%0d held=%0b",
             name, fv_cnt[0] - s_fv[0], rp_cnt[0] - s_rp[0], ep_cnt[0] - s_ep[0], ad[0], cm[0], ec[0], kh[0],
             fv_cnt[1] - s_fv[1], rp_cnt[1] - s_rp[1], ep_cnt[1] - s_ep[1], ad[1], cm[1], ec[1], kh[1]);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = '0;
      m_cmd[d]  = '0;
      m_ec[d]   = '0;
      m_has[d]  = 1'b0;
      m_t[d]    = 0;
    end
  endtask

  // Random-data frame judged by the model; force_ok makes both decoders accept it.
  task automatic random_frame(input string name, input bit force_ok);
    logic [31:0] data;
    longint      t;
    int          v;
    data = $urandom;
    if (force_ok || $urandom_range(1, 0) == 1) data[31:24] = ~data[23:16];
    if (force_ok || $urandom_range(1, 0) == 1) data[15:8]  = ~data[7:0];
    snap();
    send_frame(data, t);
    for (int d = 0; d < 2; d++) begin
      v = frame_verdict(data, d == 1);
      if (v < 0) begin
        m_addr[d] = data[15:0];
        m_cmd[d]  = data[23:16];
        m_has[d]  = 1'b1;
        m_t[d]    = t;
        check_pulses(name, d, 1, 0, 0);
      end else begin
        m_ec[d] = v[1:0];
        check_pulses(name, d, 0, 0, 1);
      end
      check_model(name, d);
    end
    report(name);
  endtask

  initial begin
    longint t;

    tbl[0] = '{data: 32'hBA45FF00, ok: 2'b11, ec: {2'd0, 2'd0},
               addr: {16'hFF00, 16'hFF00}, cmd: {8'h45, 8'h45}, held: 2'b11};
    tbl[1] = '{data: 32'hBB45FF00, ok: 2'b00, ec: {2'd1, 2'd1},
               addr: {16'hFF00, 16'hFF00}, cmd: {8'h45, 8'h45}, held: 2'b00};
    tbl[2] = '{data: 32'hA9563412, ok: 2'b01, ec: {2'd2, 2'd1},
               addr: {16'hFF00, 16'h3412}, cmd: {8'h45, 8'h56}, held: 2'b01};

    model_reset();
    repeat (5) @(negedge sys_clk);
    snap();
    for (int d = 0; d < 2; d++) begin
      check("reset.frame_valid", d, 32'(fv[d]), 32'd0);
      check("reset.key_held",    d, 32'(kh[d]), 32'd0);
      check_model("reset", d);
    end
    report("reset");
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);

    // Table: good frame, corrupted cmd_n, non-classic address.
    for (int i = 0; i < 3; i++) begin
      snap();
      send_frame(tbl[i].data, t);
      for (int d = 0; d < 2; d++) begin
        check_pulses($sformatf("tbl%0d", i), d, int'(tbl[i].ok[d]), 0, int'(!tbl[i].ok[d]));
        check($sformatf("tbl%0d.addr", i), d, 32'(ad[d]), 32'(tbl[i].addr[d*16 +: 16]));
        check($sformatf("tbl%0d.cmd", i), d, 32'(cm[d]), 32'(tbl[i].cmd[d*8 +: 8]));
        check($sformatf("tbl%0d.err_code", i), d, 32'(ec[d]), 32'(tbl[i].ec[d*2 +: 2]));
        check($sformatf("tbl%0d.key_held", i), d, 32'(kh[d]), 32'(tbl[i].held[d]));
        m_addr[d] = tbl[i].addr[d*16 +: 16];
        m_cmd[d]  = tbl[i].cmd[d*8 +: 8];
        m_ec[d]   = tbl[i].ec[d*2 +: 2];
        if (tbl[i].ok[d]) begin
          m_has[d] = 1'b1;
          m_t[d]   = t;
        end
      end
      report($sformatf("tbl%0d", i));
    end

    // Repeats: only the decoder still holding the key may pulse repeat_en.
    for (int r = 0; r < 3; r++) begin
      snap();
      send_repeat(t);
      for (int d = 0; d < 2; d++) begin
        if (held_at(d, t)) begin
          check_pulses($sformatf("rpt%0d", r), d, 0, 1, 0);
          m_t[d] = t;
        end else begin
          check_pulses($sformatf("rpt%0d", r), d, 0, 0, 0);
        end
        check_model($sformatf("rpt%0d", r), d);
      end
      report($sformatf("rpt%0d", r));
    end

    // Hold timeout after the last repeat.
    snap();
    repeat (HOLD_TICKS - 200) @(negedge sys_clk);
    check("hold_pre.key_held", 0, 32'(kh[0]), 32'd1);
    repeat (400) @(negedge sys_clk);
    check("hold_post.key_held", 0, 32'(kh[0]), 32'd0);
    for (int d = 0; d < 2; d++) check_model("hold_tmo", d);
    report("hold_tmo");

    snap();
    send_repeat(t);
    for (int d = 0; d < 2; d++) begin
      check_pulses("rpt_orphan", d, 0, 0, 0);
      check_model("rpt_orphan", d);
    end
    report("rpt_orphan");

    // Line stuck low mid-frame.
    snap();
    send_lead(1'b0);
    send_bits(32'h5, 3);
    drive(1'b0, 1500);
    drive(1'b1, 30);
    for (int d = 0; d < 2; d++) begin
      m_ec[d] = 2'd3;
      check_pulses("stuck_low", d, 0, 0, 1);
      check_model("stuck_low", d);
    end
    report("stuck_low");

    // Short glitch while the leader space is expected.
    snap();
    drive(1'b0, rnd(805, 995));
    drive(1'b1, rnd(20, 35));
    drive(1'b0, 10);
    drive(1'b1, 50);
    for (int d = 0; d < 2; d++) begin
      m_ec[d] = 2'd0;
      check_pulses("glitch", d, 0, 0, 1);
      check_model("glitch", d);
    end
    report("glitch");

    random_frame("rand0", 1'b1);
    random_frame("rand1", 1'b0);

    // Reset in the middle of a frame, then a normal frame.
    snap();
    send_lead(1'b0);
    send_bits(32'hBA45FF00, 16);
    sys_rst_n = 1'b0;
    remote_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check("midrst.frame_valid", d, 32'(fv[d]), 32'd0);
      check("midrst.repeat_en",   d, 32'(rp[d]), 32'd0);
      check("midrst.err_pulse",   d, 32'(ep[d]), 32'd0);
      check_model("midrst", d);
    end
    report("midrst");
    sys_rst_n = 1'b1;
    repeat (30) @(negedge sys_clk);

    snap();
    send_frame(32'hBA45FF00, t);
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = 16'hFF00;
      m_cmd[d]  = 8'h45;
      m_has[d]  = 1'b1;
      m_t[d]    = t;
      check_pulses("post_rst", d, 1, 0, 0);
      check_model("post_rst", d);
    end
    report("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
